// File: rtl/subdiv_pkg.sv
//------------------------------------------------------------------------------
// Module      : subdiv_pkg
// Description : Shared definitions for the subdivision pipeline: RAM address
//               width, fixed-point one, neighbor_builder state encodings and
//               RAM address helper functions.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package subdiv_pkg;

  localparam int ADDR_WIDTH = 11;

  // Fixed-point 1.0 used by the averager pass that consumes the neighbor table
  localparam logic [31:0] Q_ONE = 32'h0001_0000;

  // Top-level sequencer states
  typedef enum logic [2:0] {
    NB_IDLE    = 3'd0,
    NB_CLEAR   = 3'd1,
    NB_FACE_RD = 3'd2,
    NB_EDGE    = 3'd3,
    NB_WAIT    = 3'd4,
    NB_DONE    = 3'd5
  } nb_state_t;

  // List-insert engine states
  typedef enum logic [2:0] {
    INS_IDLE   = 3'd0,
    INS_CNT_RD = 3'd1,
    INS_SCAN   = 3'd2,
    INS_APPEND = 3'd3,
    INS_CNT_WR = 3'd4
  } ins_state_t;

  // Base word of 1-based vertex v in the neighbor RAM, truncated to the RAM width
  function automatic logic [ADDR_WIDTH-1:0] vertex_base(input logic [31:0] v,
                                                        input logic [31:0] m);
    logic [31:0] t;
    t = (v - 32'd1) * m;
    return t[ADDR_WIDTH-1:0];
  endfunction

  // Word k of face f: faces follow the 3V vertex words plus one header word
  function automatic logic [ADDR_WIDTH-1:0] face_addr(input logic [31:0] nv,
                                                      input logic [31:0] f,
                                                      input logic [1:0]  k);
    logic [31:0] t;
    t = 32'd3 * nv + 32'd1 + 32'd3 * f + {30'd0, k};
    return t[ADDR_WIDTH-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/nbr_list_insert.sv
//------------------------------------------------------------------------------
// Module      : nbr_list_insert
// Description : Inserts one directed edge (v,n) into vertex v's neighbor list
//               if n is not already present. Owns the neighbor RAM port and
//               also performs the count-word clears requested by the top.
//               All outputs are registered on the falling clock edge so the
//               RAM sees stable signals at its rising-edge sample point.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module nbr_list_insert
  import subdiv_pkg::*;
#(
  parameter int MAX_NEIGHBOR_COUNT = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr_flags,
  input  logic                  clr_we,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  input  logic                  req,
  input  logic [31:0]           v,
  input  logic [31:0]           n,
  output logic                  ack,
  output logic                  overflow,
  output logic                  RAM_NBR_EN,
  output logic [ADDR_WIDTH-1:0] RAM_NBR_A,
  output logic [3:0]            RAM_NBR_WE,
  output logic [31:0]           RAM_NBR_Di,
  input  logic [31:0]           RAM_NBR_Do
);

  localparam logic [31:0] SLOT_WORDS = 32'(MAX_NEIGHBOR_COUNT);
  localparam logic [31:0] MAX_LIST   = 32'(MAX_NEIGHBOR_COUNT - 1);

  ins_state_t            state, state_d;
  logic                  en_d, ack_d, ovf_d;
  logic [ADDR_WIDTH-1:0] a_d, base, base_d;
  logic [3:0]            we_d;
  logic [31:0]           di_d, nval, nval_d, cnt, cnt_d, j, j_d;
  logic [31:0]           cur_cnt, j_next, cnt_next;
  logic                  try_append;

  // Next-state and next-output computation for the insert engine
  always_comb begin
    state_d    = state;
    en_d       = en;
    ack_d      = 1'b0;
    ovf_d      = clr_flags ? 1'b0 : overflow;
    a_d        = RAM_NBR_A;
    we_d       = 4'h0;
    di_d       = RAM_NBR_Di;
    base_d     = base;
    nval_d     = nval;
    cnt_d      = cnt;
    j_d        = j;
    try_append = 1'b0;
    // The count is only in a register after CNT_RD; during CNT_RD use the RAM word
    cur_cnt    = (state == INS_CNT_RD) ? RAM_NBR_Do : cnt;
    j_next     = j + 32'd1;
    cnt_next   = cnt + 32'd1;

    case (state)
      INS_IDLE: begin
        if (req) begin
          base_d  = vertex_base(v, SLOT_WORDS);
          nval_d  = n;
          a_d     = vertex_base(v, SLOT_WORDS);
          state_d = INS_CNT_RD;
        end else if (clr_we) begin
          a_d  = clr_addr;
          di_d = 32'd0;
          we_d = 4'hF;
        end
      end
      INS_CNT_RD: begin
        cnt_d = RAM_NBR_Do;
        if (RAM_NBR_Do == 32'd0) begin
          try_append = 1'b1;
        end else begin
          j_d     = 32'd1;
          a_d     = base + 11'd1;
          state_d = INS_SCAN;
        end
      end
      INS_SCAN: begin
        if (RAM_NBR_Do == nval) begin
          ack_d   = 1'b1;
          state_d = INS_IDLE;
        end else if (j == cnt) begin
          try_append = 1'b1;
        end else begin
          j_d = j_next;
          a_d = base + j_next[ADDR_WIDTH-1:0];
        end
      end
      INS_APPEND: begin
        a_d     = base;
        di_d    = cnt_next;
        we_d    = 4'hF;
        state_d = INS_CNT_WR;
      end
      INS_CNT_WR: begin
        ack_d   = 1'b1;
        state_d = INS_IDLE;
      end
      default: state_d = INS_IDLE;
    endcase

    // A list with MAX_LIST entries is full: flag it and drop the edge
    if (try_append) begin
      if (cur_cnt < MAX_LIST) begin
        a_d     = base + cur_cnt[ADDR_WIDTH-1:0] + 11'd1;
        di_d    = nval;
        we_d    = 4'hF;
        state_d = INS_APPEND;
      end else begin
        ovf_d   = 1'b1;
        ack_d   = 1'b1;
        state_d = INS_IDLE;
      end
    end
  end

  // Falling-edge register bank with synchronous reset
  always_ff @(negedge clk) begin
    if (rst) begin
      state      <= INS_IDLE;
      RAM_NBR_EN <= 1'b0;
      RAM_NBR_A  <= '0;
      RAM_NBR_WE <= 4'h0;
      RAM_NBR_Di <= 32'd0;
      ack        <= 1'b0;
      overflow   <= 1'b0;
      base       <= '0;
      nval       <= 32'd0;
      cnt        <= 32'd0;
      j          <= 32'd0;
    end else begin
      state      <= state_d;
      RAM_NBR_EN <= en_d;
      RAM_NBR_A  <= a_d;
      RAM_NBR_WE <= we_d;
      RAM_NBR_Di <= di_d;
      ack        <= ack_d;
      overflow   <= ovf_d;
      base       <= base_d;
      nval       <= nval_d;
      cnt        <= cnt_d;
      j          <= j_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/neighbor_builder.sv
//------------------------------------------------------------------------------
// Module      : neighbor_builder
// Description : Builds the per-vertex neighbor table in RAM_NBR from the face
//               list in RAM_OBJ. Clears every count word, reads each face,
//               and hands its six directed edges to nbr_list_insert.
//               Optional macro NBR_BOUNDS_CHECK_EN rejects faces whose
//               indices are 0 or exceed the vertex count.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module neighbor_builder
  import subdiv_pkg::*;
#(
  parameter int MAX_NEIGHBOR_COUNT = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           vertex_count,
  input  logic [31:0]           face_count,
  output logic                  RAM_OBJ_EN,
  output logic [ADDR_WIDTH-1:0] RAM_OBJ_A,
  output logic [3:0]            RAM_OBJ_WE,
  output logic [31:0]           RAM_OBJ_Di,
  input  logic [31:0]           RAM_OBJ_Do,
  output logic                  RAM_NBR_EN,
  output logic [ADDR_WIDTH-1:0] RAM_NBR_A,
  output logic [3:0]            RAM_NBR_WE,
  output logic [31:0]           RAM_NBR_Di,
  input  logic [31:0]           RAM_NBR_Do,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  bad_index
);

  localparam logic [31:0] SLOT_WORDS = 32'(MAX_NEIGHBOR_COUNT);

  nb_state_t             state, state_d;
  logic                  obj_en_d, busy_d, done_d, bad_d;
  logic [ADDR_WIDTH-1:0] obj_a_d, clr_addr;
  logic [31:0]           nv, nv_d, nf, nf_d, clr_v, clr_v_d, face_idx, face_d;
  logic [31:0]           va, va_d, vb, vb_d, vc, vc_d, edge_v, edge_n;
  logic [31:0]           clr_next, face_next;
  logic [1:0]            rd_k, rd_k_d;
  logic [2:0]            edge_idx, edge_d;
  logic                  adv_edge, adv_face, face_reject;
  logic                  clr_we, flags_clr, ins_req, ins_ack;

  // The object RAM is read-only
  assign RAM_OBJ_WE = 4'h0;
  assign RAM_OBJ_Di = 32'd0;

  // Select the (v,n) pair for the current edge: ab, ba, bc, cb, ca, ac
  always_comb begin
    edge_v = va;
    edge_n = vb;
    case (edge_idx)
      3'd0: begin edge_v = va; edge_n = vb; end
      3'd1: begin edge_v = vb; edge_n = va; end
      3'd2: begin edge_v = vb; edge_n = vc; end
      3'd3: begin edge_v = vc; edge_n = vb; end
      3'd4: begin edge_v = vc; edge_n = va; end
      3'd5: begin edge_v = va; edge_n = vc; end
      default: begin edge_v = va; edge_n = vb; end
    endcase
  end

  // Sequencer next-state and next-output logic
  always_comb begin
    state_d   = state;
    obj_en_d  = RAM_OBJ_EN;
    obj_a_d   = RAM_OBJ_A;
    busy_d    = busy;
    done_d    = 1'b0;
    bad_d     = bad_index;
    nv_d      = nv;
    nf_d      = nf;
    clr_v_d   = clr_v;
    face_d    = face_idx;
    rd_k_d    = rd_k;
    va_d      = va;
    vb_d      = vb;
    vc_d      = vc;
    edge_d    = edge_idx;
    adv_edge  = 1'b0;
    adv_face  = 1'b0;
    clr_we    = 1'b0;
    flags_clr = 1'b0;
    ins_req   = 1'b0;
    clr_next  = clr_v + 32'd1;
    face_next = face_idx + 32'd1;
    clr_addr  = vertex_base(clr_next, SLOT_WORDS);
`ifdef NBR_BOUNDS_CHECK_EN
    face_reject = (va == 32'd0) || (va > nv) ||
                  (vb == 32'd0) || (vb > nv) ||
                  (vc == 32'd0) || (vc > nv);
`else
    face_reject = 1'b0;
`endif

    case (state)
      NB_IDLE: begin
        if (start) begin
          obj_en_d  = 1'b1;
          busy_d    = 1'b1;
          bad_d     = 1'b0;
          flags_clr = 1'b1;
          nv_d      = vertex_count;
          nf_d      = face_count;
          clr_v_d   = 32'd0;
          state_d   = NB_CLEAR;
        end
      end
      NB_CLEAR: begin
        // One extra cycle after the last request lets the final clear land
        if (clr_v < nv) begin
          clr_we  = 1'b1;
          clr_v_d = clr_next;
        end else if (nf == 32'd0) begin
          state_d = NB_DONE;
        end else begin
          face_d  = 32'd0;
          rd_k_d  = 2'd0;
          obj_a_d = face_addr(nv, 32'd0, 2'd0);
          state_d = NB_FACE_RD;
        end
      end
      NB_FACE_RD: begin
        case (rd_k)
          2'd0: begin
            va_d    = RAM_OBJ_Do;
            obj_a_d = face_addr(nv, face_idx, 2'd1);
            rd_k_d  = 2'd1;
          end
          2'd1: begin
            vb_d    = RAM_OBJ_Do;
            obj_a_d = face_addr(nv, face_idx, 2'd2);
            rd_k_d  = 2'd2;
          end
          default: begin
            vc_d    = RAM_OBJ_Do;
            edge_d  = 3'd0;
            state_d = NB_EDGE;
          end
        endcase
      end
      NB_EDGE: begin
        if (face_reject) begin
          bad_d    = 1'b1;
          adv_face = 1'b1;
        end else if (edge_v == edge_n) begin
          adv_edge = 1'b1;
        end else begin
          ins_req = 1'b1;
          state_d = NB_WAIT;
        end
      end
      NB_WAIT: begin
        if (ins_ack) adv_edge = 1'b1;
      end
      NB_DONE: begin
        state_d = NB_IDLE;
      end
      default: state_d = NB_IDLE;
    endcase

    if (adv_edge) begin
      if (edge_idx == 3'd5) begin
        adv_face = 1'b1;
      end else begin
        edge_d  = edge_idx + 3'd1;
        state_d = NB_EDGE;
      end
    end

    if (adv_face) begin
      if (face_idx == nf - 32'd1) begin
        state_d = NB_DONE;
      end else begin
        face_d  = face_next;
        rd_k_d  = 2'd0;
        obj_a_d = face_addr(nv, face_next, 2'd0);
        state_d = NB_FACE_RD;
      end
    end

    if (state_d == NB_DONE) begin
      done_d   = 1'b1;
      busy_d   = 1'b0;
      obj_en_d = 1'b0;
    end
  end

  // Falling-edge register bank with synchronous reset
  always_ff @(negedge clk) begin
    if (rst) begin
      state      <= NB_IDLE;
      RAM_OBJ_EN <= 1'b0;
      RAM_OBJ_A  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bad_index  <= 1'b0;
      nv         <= 32'd0;
      nf         <= 32'd0;
      clr_v      <= 32'd0;
      face_idx   <= 32'd0;
      rd_k       <= 2'd0;
      va         <= 32'd0;
      vb         <= 32'd0;
      vc         <= 32'd0;
      edge_idx   <= 3'd0;
    end else begin
      state      <= state_d;
      RAM_OBJ_EN <= obj_en_d;
      RAM_OBJ_A  <= obj_a_d;
      busy       <= busy_d;
      done       <= done_d;
      bad_index  <= bad_d;
      nv         <= nv_d;
      nf         <= nf_d;
      clr_v      <= clr_v_d;
      face_idx   <= face_d;
      rd_k       <= rd_k_d;
      va         <= va_d;
      vb         <= vb_d;
      vc         <= vc_d;
      edge_idx   <= edge_d;
    end
  end

  nbr_list_insert #(
    .MAX_NEIGHBOR_COUNT(MAX_NEIGHBOR_COUNT)
  ) u_insert (
    .clk        (clk),
    .rst        (rst),
    .en         (RAM_OBJ_EN),
    .clr_flags  (flags_clr),
    .clr_we     (clr_we),
    .clr_addr   (clr_addr),
    .req        (ins_req),
    .v          (edge_v),
    .n          (edge_n),
    .ack        (ins_ack),
    .overflow   (overflow),
    .RAM_NBR_EN (RAM_NBR_EN),
    .RAM_NBR_A  (RAM_NBR_A),
    .RAM_NBR_WE (RAM_NBR_WE),
    .RAM_NBR_Di (RAM_NBR_Di),
    .RAM_NBR_Do (RAM_NBR_Do)
  );

endmodule

`default_nettype wire

// File: tb/tb_neighbor_builder.sv
//------------------------------------------------------------------------------
// Module      : tb_neighbor_builder
// Description : Self-checking bench for neighbor_builder with behavioural
//               object and neighbor RAMs. Slot size 4 lets the fan scenario
//               fill a list while the small meshes still fit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_neighbor_builder;
  import subdiv_pkg::*;

  localparam int M = 4;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] vertex_count, face_count;
  logic        RAM_OBJ_EN, RAM_NBR_EN;
  logic [10:0] RAM_OBJ_A, RAM_NBR_A;
  logic [3:0]  RAM_OBJ_WE, RAM_NBR_WE;
  logic [31:0] RAM_OBJ_Di, RAM_NBR_Di, RAM_OBJ_Do, RAM_NBR_Do;
  logic        busy, done, overflow, bad_index;

  logic [31:0] obj_mem [0:2047];
  logic [31:0] nbr_mem [0:2047];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0]             nv;
    logic [7:0]             nf;
    logic [3:0][2:0][7:0]   face;  // face[f][k]
    logic [5:0][3:0][7:0]   exp;   // exp[v-1][word]
    logic                   ovf;
    logic                   bad;
  } vec_t;

  vec_t vec [4];

  always #5 clk = ~clk;

  neighbor_builder #(.MAX_NEIGHBOR_COUNT(M)) dut (
    .clk(clk), .rst(rst), .start(start),
    .vertex_count(vertex_count), .face_count(face_count),
    .RAM_OBJ_EN(RAM_OBJ_EN), .RAM_OBJ_A(RAM_OBJ_A), .RAM_OBJ_WE(RAM_OBJ_WE),
    .RAM_OBJ_Di(RAM_OBJ_Di), .RAM_OBJ_Do(RAM_OBJ_Do),
    .RAM_NBR_EN(RAM_NBR_EN), .RAM_NBR_A(RAM_NBR_A), .RAM_NBR_WE(RAM_NBR_WE),
    .RAM_NBR_Di(RAM_NBR_Di), .RAM_NBR_Do(RAM_NBR_Do),
    .busy(busy), .done(done), .overflow(overflow), .bad_index(bad_index)
  );

  // Object RAM: rising-edge synchronous read
  always @(posedge clk) begin
    if (RAM_OBJ_EN) RAM_OBJ_Do <= obj_mem[RAM_OBJ_A];
  end

  // Neighbor RAM: rising-edge write and read-old-data
  always @(posedge clk) begin
    if (RAM_NBR_EN) begin
      if (RAM_NBR_WE == 4'hF) nbr_mem[RAM_NBR_A] <= RAM_NBR_Di;
      RAM_NBR_Do <= nbr_mem[RAM_NBR_A];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_face(input int i, input int f, input int a, input int b, input int c);
    vec[i].face[f][0] = 8'(a);
    vec[i].face[f][1] = 8'(b);
    vec[i].face[f][2] = 8'(c);
  endtask

  task automatic set_exp(input int i, input int v, input int c, input int n1, input int n2, input int n3);
    vec[i].exp[v-1][0] = 8'(c);
    vec[i].exp[v-1][1] = 8'(n1);
    vec[i].exp[v-1][2] = 8'(n2);
    vec[i].exp[v-1][3] = 8'(n3);
  endtask

  task automatic load_start(input int idx);
    int nv;
    nv = int'(vec[idx].nv);
    for (int f = 0; f < int'(vec[idx].nf); f++)
      for (int k = 0; k < 3; k++)
        obj_mem[3*nv + 1 + 3*f + k] = {24'd0, vec[idx].face[f][k]};
    vertex_count = 32'(vec[idx].nv);
    face_count   = 32'(vec[idx].nf);
    start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    check($sformatf("vec%0d busy after start", idx), {31'd0, busy}, 32'd1);
  endtask

  task automatic run_vec(input int idx);
    int  dones;
    bit  seen;
    int  c;
    load_start(idx);
    seen  = 1'b0;
    dones = 0;
    for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
      @(posedge clk);
      if (done) begin seen = 1'b1; dones++; end
    end
    check($sformatf("vec%0d done seen", idx), {31'd0, seen}, 32'd1);
    repeat (4) begin
      @(posedge clk);
      if (done) dones++;
    end
    check($sformatf("vec%0d done pulses", idx), 32'(dones), 32'd1);
    check($sformatf("vec%0d busy at end", idx), {31'd0, busy}, 32'd0);
    check($sformatf("vec%0d overflow", idx), {31'd0, overflow}, {31'd0, vec[idx].ovf});
    check($sformatf("vec%0d bad_index", idx), {31'd0, bad_index}, {31'd0, vec[idx].bad});
    for (int v = 1; v <= int'(vec[idx].nv); v++) begin
      c = int'(vec[idx].exp[v-1][0]);
      check($sformatf("vec%0d v%0d count", idx, v), nbr_mem[(v-1)*M], 32'(c));
      for (int w = 1; w <= c; w++)
        check($sformatf("vec%0d v%0d word%0d", idx, v, w), nbr_mem[(v-1)*M + w],
              {24'd0, vec[idx].exp[v-1][w]});
    end
  endtask

  initial begin
    int  wr, dones;
    bit  found;

    // Vector table: meshes with hand-derived neighbor lists
    for (int i = 0; i < 4; i++) vec[i] = '0;
    vec[0].nv = 8'd3; vec[0].nf = 8'd1;
    set_face(0, 0, 1, 2, 3);
    set_exp(0, 1, 2, 2, 3, 0); set_exp(0, 2, 2, 1, 3, 0); set_exp(0, 3, 2, 2, 1, 0);

    vec[1].nv = 8'd4; vec[1].nf = 8'd2;
    set_face(1, 0, 1, 2, 3); set_face(1, 1, 1, 3, 4);
    set_exp(1, 1, 3, 2, 3, 4); set_exp(1, 2, 2, 1, 3, 0);
    set_exp(1, 3, 3, 2, 1, 4); set_exp(1, 4, 2, 3, 1, 0);

    vec[2].nv = 8'd6; vec[2].nf = 8'd4; vec[2].ovf = 1'b1;
    set_face(2, 0, 1, 2, 3); set_face(2, 1, 1, 3, 4);
    set_face(2, 2, 1, 4, 5); set_face(2, 3, 1, 5, 6);
    set_exp(2, 1, 3, 2, 3, 4); set_exp(2, 2, 2, 1, 3, 0); set_exp(2, 3, 3, 2, 1, 4);
    set_exp(2, 4, 3, 3, 1, 5); set_exp(2, 5, 3, 4, 1, 6); set_exp(2, 6, 2, 5, 1, 0);

    vec[3].nv = 8'd3; vec[3].nf = 8'd1;
    set_face(3, 0, 1, 2, 7);
`ifdef NBR_BOUNDS_CHECK_EN
    vec[3].bad = 1'b1;
    set_exp(3, 1, 0, 0, 0, 0); set_exp(3, 2, 0, 0, 0, 0); set_exp(3, 3, 0, 0, 0, 0);
`else
    vec[3].bad = 1'b0;
    set_exp(3, 1, 2, 2, 7, 0); set_exp(3, 2, 2, 1, 7, 0); set_exp(3, 3, 0, 0, 0, 0);
`endif

    rst = 1'b1; start = 1'b0; vertex_count = 32'd0; face_count = 32'd0;
    repeat (3) @(posedge clk);
    check("reset busy",       {31'd0, busy},       32'd0);
    check("reset done",       {31'd0, done},       32'd0);
    check("reset overflow",   {31'd0, overflow},   32'd0);
    check("reset bad_index",  {31'd0, bad_index},  32'd0);
    check("reset obj EN",     {31'd0, RAM_OBJ_EN}, 32'd0);
    check("reset nbr EN",     {31'd0, RAM_NBR_EN}, 32'd0);
    check("reset nbr WE",     {28'd0, RAM_NBR_WE}, 32'd0);
    check("reset obj A",      {21'd0, RAM_OBJ_A},  32'd0);
    check("reset nbr A",      {21'd0, RAM_NBR_A},  32'd0);
    check("reset nbr Di",     RAM_NBR_Di,          32'd0);
    check("obj WE constant",  {28'd0, RAM_OBJ_WE}, 32'd0);
    check("obj Di constant",  RAM_OBJ_Di,          32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 4; i++) begin
      if (i > 0)
        check($sformatf("vec%0d overflow before start", i), {31'd0, overflow}, {31'd0, vec[i-1].ovf});
      run_vec(i);
    end

    // Reset while the insert engine is scanning, then rebuild from scratch
    load_start(1);
    found = 1'b0;
    for (int cyc = 0; cyc < 500 && !found; cyc++) begin
      @(posedge clk);
      if (dut.u_insert.state == INS_SCAN) found = 1'b1;
    end
    check("reached SCAN", {31'd0, found}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    rst = 1'b0;
    check("mid reset busy", {31'd0, busy},       32'd0);
    check("mid reset WE",   {28'd0, RAM_NBR_WE}, 32'd0);
    check("mid reset done", {31'd0, done},       32'd0);
    repeat (2) @(posedge clk);
    run_vec(1);

    // F=0: only count words are cleared; a start during the run is ignored
    vertex_count = 32'd5; face_count = 32'd0;
    start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    check("F0 busy after start", {31'd0, busy}, 32'd1);
    wr = 0; dones = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk);
      if (RAM_NBR_WE == 4'hF) wr++;
      if (done) dones++;
      start = (cyc == 1);
    end
    start = 1'b0;
    check("F0 write count", 32'(wr), 32'd5);
    check("F0 done pulses", 32'(dones), 32'd1);
    check("F0 busy at end", {31'd0, busy}, 32'd0);
    for (int v = 1; v <= 5; v++)
      check($sformatf("F0 v%0d count", v), nbr_mem[(v-1)*M], 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
